scr1_pipe_mprf_win: RTL and testbench
=====================================

# scr1_pipe_mprf_win

Parametrised multi-port register file for the SCR1 pipeline, successor to the single-window MPRF. It provides NRD combinational read ports, one write port, and a configurable shift window: a fixed ordered set of architectural registers that shift as a unit on SM4-class instructions. It also adds an optional same-cycle write bypass and a sequential scrub engine that zeroes the file without a reset. It sits between the EXU and the architectural state, replacing the fixed x5/x6/x7/x28 wiring.

## Interface
- XLEN, 32: data width.
- NREGS, 32: architectural register count including x0; 16 selects RVE.
- AW, $clog2(NREGS): address width (derived).
- NRD, 2: number of read ports.
- WIN_DEPTH, 4: shift-window length, ≥2.
- WIN_MAP, {28,7,6,5}: window addresses, head first; all nonzero, distinct, < NREGS.
- BYPASS_EN, 1: forward the accepted write's next-state value to the read ports.
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- rd_addr  in  NRD×AW  read addresses.
- rd_data  out  NRD×XLEN  read data; x0 reads 0.
- w_req  in  1  write request.
- w_addr  in  AW  write address.
- w_data  in  XLEN  write data.
- shift_req  in  1  qualifies w_req as a window shift.
- w_rdy  out  1  write/shift accepted when high.
- win_data  out  WIN_DEPTH×XLEN  registered window contents, head first.
- clr_req  in  1  start scrub.
- busy  out  1  scrub in progress.

## Operation
- Accepted write: w_req & w_rdy. If w_addr≠0, reg[w_addr] ← w_data.
- Accepted shift: w_req & w_rdy & shift_req. reg[WIN_MAP[0]] ← w_data; for i≥1, reg[WIN_MAP[i]] ← old reg[WIN_MAP[i−1]]. The plain write to w_addr also happens.
- Collision: when a plain write and a shift target the same window register, the shift value wins.
- Reads are combinational. With BYPASS_EN=1, a read whose address would change on an accepted op returns that register's next-state value, covering both the plain write and shift effects. With BYPASS_EN=0, reads return the current value. win_data is never bypassed.
- Scrub FSM states:
  - IDLE: on clr_req go to SCRUB, idx=1.
  - SCRUB: reg[idx] ← 0 each cycle. When idx==NREGS−1, go to IDLE; otherwise idx++.
- busy = (state==SCRUB). w_rdy = !busy. clr_req is ignored while busy.
- A write offered in the same cycle as the accepting clr_req is still accepted, because w_rdy is high in IDLE. Scrub starts the following cycle.
- Reset: all registers 0, state IDLE, idx 1. Reset mid-scrub aborts the scrub and clears everything.

## Timing
- Write and shift latency is 1 cycle; new values are visible on rd_data without bypass and on win_data at the next cycle.
- Scrub lasts NREGS−1 cycles of busy=1 (31 for the defaults). w_rdy returns high the cycle after the last scrub write.
- Reset values: rd_data = 0 for any address, win_data all 0, busy 0, w_rdy 1.
- Reads during scrub return partially cleared contents; no blocking.
- w_req with w_rdy=0 is dropped. The EXU must hold the request until w_rdy is high.

## Structure
- Package scr1_mprf_win_pkg contains:
  - Enum type_scr1_mprf_scrub_e {IDLE, SCRUB}.
  - Default WIN_MAP constant.
  - Function win_index(addr), returning the window position or −1.
- Sub-module scr1_mprf_scrub_fsm holds the state, idx counter, busy and clear-enable outputs.
- The storage array, write/shift muxing and bypass live in the top module.

## Test plan
- Reset, then read x0, x5 and x28 on both ports: all 0; busy=0, w_rdy=1.
- Write x5=0xA5A5A5A5, then read port0=x5 in the next cycle: 0xA5A5A5A5. With BYPASS_EN=1, the same-cycle read also returns 0xA5A5A5A5.
- Four shifts with w_data 1, 2, 3, 4 and w_addr=0: win_data = {4,3,2,1}, so x28=4, x7=3, x6=2, x5=1.
- Shift with w_data=9 and w_addr=7 in the same cycle: x28=9 and x7 equals the old x28, because the shift wins. The same-cycle bypassed read of x7 returns the old x28.
- Fill registers, pulse clr_req: busy is high for exactly 31 cycles; a write offered mid-scrub is dropped (w_rdy=0); afterwards all registers read 0.
- Assert rst at scrub cycle 10: busy=0 the next cycle, all registers 0, and a new clr_req restarts at idx=1.

Source files
------------

// File: rtl/scr1_mprf_win_pkg.sv
// Shared types and constants for the windowed multi-port register file.
package scr1_mprf_win_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SCRUB = 1'b1
    } type_scr1_mprf_scrub_e;

    localparam int SCR1_MPRF_WIN_DEPTH_DFLT = 4;
    localparam int SCR1_MPRF_WIN_MAP_DFLT [SCR1_MPRF_WIN_DEPTH_DFLT] = '{28, 7, 6, 5};

    // Position of addr inside the default window (0 = head), or -1 when outside it.
    function automatic int win_index(input int addr);
        int pos;
        pos = -1;
        for (int i = SCR1_MPRF_WIN_DEPTH_DFLT - 1; i >= 0; i--) begin
            if (SCR1_MPRF_WIN_MAP_DFLT[i] == addr) begin
                pos = i;
            end
        end
        return pos;
    endfunction

endpackage

// File: rtl/scr1_mprf_scrub_fsm.sv
// Sequential scrub engine: walks idx from 1 to NREGS-1, requesting one zero write per cycle.
module scr1_mprf_scrub_fsm
    import scr1_mprf_win_pkg::*;
#(
    parameter int NREGS = 32,
    parameter int AW    = $clog2(NREGS)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr_req_i,
    output logic          busy_o,
    output logic          clr_en_o,
    output logic [AW-1:0] clr_idx_o
);

    type_scr1_mprf_scrub_e state_q, state_d;
    logic [AW-1:0]         idx_q, idx_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= AW'(1);
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        case (state_q)
            IDLE: begin
                if (clr_req_i) begin
                    state_d = SCRUB;
                    idx_d   = AW'(1);
                end
            end
            SCRUB: begin
                if (idx_q == AW'(NREGS - 1)) begin
                    state_d = IDLE;
                    idx_d   = AW'(1);
                end else begin
                    idx_d = idx_q + AW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                idx_d   = AW'(1);
            end
        endcase
    end

    assign busy_o    = (state_q == SCRUB);
    assign clr_en_o  = (state_q == SCRUB);
    assign clr_idx_o = idx_q;

endmodule

// File: rtl/scr1_pipe_mprf_win.sv
// Multi-port register file with a shifting register window, optional write bypass
// and a reset-free scrub engine.
module scr1_pipe_mprf_win
    import scr1_mprf_win_pkg::*;
#(
    parameter int XLEN                 = 32,
    parameter int NREGS                = 32,
    parameter int AW                   = $clog2(NREGS),
    parameter int NRD                  = 2,
    parameter int WIN_DEPTH            = SCR1_MPRF_WIN_DEPTH_DFLT,
    parameter int WIN_MAP [WIN_DEPTH]  = SCR1_MPRF_WIN_MAP_DFLT,
    parameter bit BYPASS_EN            = 1'b1
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NRD-1:0][AW-1:0]          rd_addr,
    output logic [NRD-1:0][XLEN-1:0]        rd_data,
    input  logic                            w_req,
    input  logic [AW-1:0]                   w_addr,
    input  logic [XLEN-1:0]                 w_data,
    input  logic                            shift_req,
    output logic                            w_rdy,
    output logic [WIN_DEPTH-1:0][XLEN-1:0]  win_data,
    input  logic                            clr_req,
    output logic                            busy
);

    logic            clr_en;
    logic [AW-1:0]   clr_idx;
    logic            wr_acc;
    logic            shift_acc;

    logic [XLEN-1:0] reg_q [NREGS];
    logic [XLEN-1:0] reg_d [NREGS];
    logic [XLEN-1:0] byp_d [NREGS];

    scr1_mprf_scrub_fsm #(
        .NREGS (NREGS),
        .AW    (AW)
    ) i_scrub_fsm (
        .clk       (clk),
        .rst       (rst),
        .clr_req_i (clr_req),
        .busy_o    (busy),
        .clr_en_o  (clr_en),
        .clr_idx_o (clr_idx)
    );

    assign w_rdy     = !busy;
    assign wr_acc    = w_req & w_rdy;
    assign shift_acc = wr_acc & shift_req;

    // Next state from the accepted write/shift only; the shift is applied last so it wins collisions.
    always_comb begin
        byp_d = reg_q;
        if (wr_acc && (w_addr != '0)) begin
            byp_d[w_addr] = w_data;
        end
        if (shift_acc) begin
            byp_d[AW'(WIN_MAP[0])] = w_data;
            for (int i = 1; i < WIN_DEPTH; i++) begin
                byp_d[AW'(WIN_MAP[i])] = reg_q[AW'(WIN_MAP[i-1])];
            end
        end
    end

    // Scrub writes never coincide with accepted ops because w_rdy is low while scrubbing.
    always_comb begin
        reg_d = byp_d;
        if (clr_en) begin
            reg_d[clr_idx] = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < NREGS; r++) begin
                reg_q[r] <= '0;
            end
        end else begin
            reg_q <= reg_d;
        end
    end

    for (genvar p = 0; p < NRD; p++) begin : g_rd
        always_comb begin
            rd_data[p] = '0;
            if (rd_addr[p] != '0) begin
                rd_data[p] = BYPASS_EN ? byp_d[rd_addr[p]] : reg_q[rd_addr[p]];
            end
        end
    end

    // Head lands in the most significant slot so {head, ..., tail} reads naturally.
    for (genvar w = 0; w < WIN_DEPTH; w++) begin : g_win
        assign win_data[WIN_DEPTH-1-w] = reg_q[AW'(WIN_MAP[w])];
    end

endmodule

// File: tb/tb_scr1_pipe_mprf_win.sv
// Scoreboard bench for scr1_pipe_mprf_win: stimulus pushes expectations, a monitor pops and compares.
module tb_scr1_pipe_mprf_win;

    logic              clk = 1'b0;
    logic              rst;
    logic [1:0][4:0]   rd_addr;
    logic [1:0][31:0]  rd_data;
    logic              w_req;
    logic [4:0]        w_addr;
    logic [31:0]       w_data;
    logic              shift_req;
    logic              w_rdy;
    logic [3:0][31:0]  win_data;
    logic              clr_req;
    logic              busy;

    always #5 clk = ~clk;

    scr1_pipe_mprf_win #(
        .XLEN      (32),
        .NREGS     (32),
        .NRD       (2),
        .WIN_DEPTH (4),
        .BYPASS_EN (1'b1)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .w_req     (w_req),
        .w_addr    (w_addr),
        .w_data    (w_data),
        .shift_req (shift_req),
        .w_rdy     (w_rdy),
        .win_data  (win_data),
        .clr_req   (clr_req),
        .busy      (busy)
    );

    typedef struct {
        bit          chk;
        logic [31:0]  rd0;
        logic [31:0]  rd1;
        logic [127:0] win;
        bit          busy;
        bit          rdy;
    } exp_t;

    exp_t        sbq[$];
    int          total = 0;
    int          bad   = 0;

    // Reference model: architectural register values plus scrub progress.
    int unsigned m [32];
    bit          scrubbing = 1'b0;
    int          sc_next   = 1;

    task automatic cmp32(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic cmp128(input string nm, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic cyc(input bit r, input bit wq, input int wa, input logic [31:0] wd,
                       input bit sh, input bit cl, input int a0, input int a1, input bit chk = 1'b1);
        exp_t        e;
        int unsigned nx [32];
        bit          acc;
        @(posedge clk);
        #1;
        rst        = r;
        w_req      = wq;
        w_addr     = wa[4:0];
        w_data     = wd;
        shift_req  = sh;
        clr_req    = cl;
        rd_addr[0] = a0[4:0];
        rd_addr[1] = a1[4:0];

        acc = wq && !scrubbing;
        nx  = m;
        if (acc && wa != 0) nx[wa] = wd;
        if (acc && sh) begin
            nx[28] = wd;
            nx[7]  = m[28];
            nx[6]  = m[7];
            nx[5]  = m[6];
        end
        e.chk  = chk;
        e.rd0  = (a0 == 0) ? 32'd0 : nx[a0];
        e.rd1  = (a1 == 0) ? 32'd0 : nx[a1];
        e.win  = {m[28], m[7], m[6], m[5]};
        e.busy = scrubbing;
        e.rdy  = !scrubbing;
        sbq.push_back(e);

        if (r) begin
            for (int i = 0; i < 32; i++) m[i] = 0;
            scrubbing = 1'b0;
            sc_next   = 1;
        end else begin
            m = nx;
            if (scrubbing) begin
                m[sc_next] = 0;
                if (sc_next == 31) scrubbing = 1'b0;
                else sc_next++;
            end else if (cl) begin
                scrubbing = 1'b1;
                sc_next   = 1;
            end
        end
    endtask

    task automatic idle_rd(input int a0, input int a1);
        cyc(1'b0, 1'b0, 0, 32'd0, 1'b0, 1'b0, a0, a1);
    endtask

    task automatic read_all();
        for (int i = 0; i < 16; i++) idle_rd(i, i + 16);
    endtask

    task automatic fill(input int n);
        for (int i = 0; i < n; i++)
            cyc(1'b0, 1'b1, $urandom_range(31, 1), $urandom, 1'b0, 1'b0, $urandom_range(31, 0), $urandom_range(31, 0));
    endtask

    // Runs the rest of a scrub, offering writes while the model says busy, and checks its length.
    task automatic run_scrub(input string nm, input int want);
        int cnt;
        bit mb;
        cnt = 0;
        for (int k = 0; k < 40; k++) begin
            mb = scrubbing;
            cyc(1'b0, mb, $urandom_range(31, 1), $urandom, 1'b0, 1'b0, k % 32, (k + 16) % 32);
            if (busy) cnt++;
            if (!mb && !busy) break;
        end
        cmp32(nm, cnt, want);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (sbq.size() > 0) begin
                e = sbq.pop_front();
                if (e.chk) begin
                    cmp32("rd0", rd_data[0], e.rd0);
                    cmp32("rd1", rd_data[1], e.rd1);
                    cmp128("win", win_data, e.win);
                    cmp32("busy", {31'd0, busy}, {31'd0, e.busy});
                    cmp32("w_rdy", {31'd0, w_rdy}, {31'd0, e.rdy});
                end
            end
        end
    end

    initial begin : stim
        rst = 1'b1; w_req = 1'b0; w_addr = '0; w_data = '0;
        shift_req = 1'b0; clr_req = 1'b0; rd_addr = '0;
        for (int i = 0; i < 32; i++) m[i] = 0;

        cyc(1'b1, 1'b0, 0, 32'd0, 1'b0, 1'b0, 0, 0, 1'b0);
        cyc(1'b1, 1'b0, 0, 32'd0, 1'b0, 1'b0, 0, 5);
        idle_rd(0, 5);
        idle_rd(28, 0);
        idle_rd(5, 28);

        cyc(1'b0, 1'b1, 5, 32'hA5A5_A5A5, 1'b0, 1'b0, 5, 0);
        idle_rd(5, 5);

        for (int i = 1; i <= 4; i++)
            cyc(1'b0, 1'b1, 0, i, 1'b1, 1'b0, 28, 5);
        idle_rd(28, 7);
        idle_rd(6, 5);

        cyc(1'b0, 1'b1, 7, 32'd9, 1'b1, 1'b0, 7, 28);
        idle_rd(7, 28);

        fill(24);
        cyc(1'b0, 1'b0, 0, 32'd0, 1'b0, 1'b1, 1, 2);
        run_scrub("scrub_len", 31);
        read_all();

        fill(24);
        cyc(1'b0, 1'b0, 0, 32'd0, 1'b0, 1'b1, 5, 28);
        for (int k = 0; k < 10; k++) idle_rd(k, 31 - k);
        cyc(1'b1, 1'b0, 0, 32'd0, 1'b0, 1'b0, 3, 12);
        idle_rd(5, 28);
        cmp32("busy_after_rst", {31'd0, busy}, 32'd0);
        read_all();
        fill(8);
        cyc(1'b0, 1'b0, 0, 32'd0, 1'b0, 1'b1, 7, 6);
        run_scrub("scrub_len_restart", 31);
        read_all();

        for (int n = 0; n < 400; n++) begin
            cyc(($urandom_range(99, 0) == 0), ($urandom_range(1, 0) == 1), $urandom_range(31, 0),
                $urandom, ($urandom_range(3, 0) == 0), ($urandom_range(39, 0) == 0),
                $urandom_range(31, 0), $urandom_range(31, 0));
        end
        idle_rd(28, 5);

        for (int k = 0; k < 5 && sbq.size() > 0; k++) @(negedge clk);
        @(negedge clk);
        cmp32("scoreboard_drained", sbq.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
